// File: rtl/temporizador_pkg.sv
// rtl/temporizador_pkg.sv - shared state encoding and defaults for the arbitrated timer
package temporizador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CONTA = 2'b01,
    FIM   = 2'b10
  } estado_t;

  localparam int W_PADRAO = 8;

  function automatic logic [1:0] um_quente(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/contador_m.sv
// rtl/contador_m.sv - modulo-M counter with async/sync clear and terminal-count pulse
module contador_m #(
  parameter int M = 1000,
  parameter int N = $clog2(M)
) (
  input  logic         clock,
  input  logic         zera_as,
  input  logic         zera_s,
  input  logic         conta,
  output logic [N-1:0] Q,
  output logic         fim,
  output logic         meio
);

  localparam logic [N-1:0] ULTIMO = N'(M - 1);
  localparam logic [N-1:0] METADE = N'(M / 2 - 1);

  always_ff @(posedge clock or posedge zera_as) begin
    if (zera_as) begin
      Q <= '0;
    end else if (zera_s) begin
      Q <= '0;
    end else if (conta) begin
      Q <= (Q == ULTIMO) ? '0 : Q + 1'b1;
    end
  end

  assign fim  = conta && (Q == ULTIMO);
  assign meio = conta && (Q == METADE);

endmodule

// File: rtl/arbitro_temporizador.sv
// rtl/arbitro_temporizador.sv - round-robin arbiter granting one shared interval timer to two requesters
module arbitro_temporizador
  import temporizador_pkg::*;
#(
  parameter int M = 1000,
  parameter int W = W_PADRAO
) (
  input  logic         clock,
  input  logic         zera_as_n,
  input  logic [1:0]   req,
  input  logic [W-1:0] dur0,
  input  logic [W-1:0] dur1,
  output logic [1:0]   gnt,
  output logic [1:0]   done,
  output logic         ocupado,
  output logic [W-1:0] restante
);

  localparam int N = $clog2(M);

  estado_t        estado;
  logic           rr;
  logic           dono;
  logic           vencedor;
  logic [W-1:0]   dur_vencedor;
  logic           zera_s;
  logic           conta;
  logic           fim;
  logic [N-1:0]   pre_q_unused;
  logic           meio_unused;

  // A lone requester always wins; rr only breaks ties.
  always_comb begin
    vencedor     = (req == 2'b11) ? rr : req[1];
    dur_vencedor = vencedor ? dur1 : dur0;
    zera_s       = (estado == IDLE) && (req != 2'b00);
    conta        = (estado == CONTA);
  end

  contador_m #(
    .M(M),
    .N(N)
  ) u_prescaler (
    .clock  (clock),
    .zera_as(~zera_as_n),
    .zera_s (zera_s),
    .conta  (conta),
    .Q      (pre_q_unused),
    .fim    (fim),
    .meio   (meio_unused)
  );

  always_ff @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n) begin
      estado   <= IDLE;
      rr       <= 1'b0;
      dono     <= 1'b0;
      gnt      <= 2'b00;
      done     <= 2'b00;
      ocupado  <= 1'b0;
      restante <= '0;
    end else begin
      case (estado)
        IDLE: begin
          done <= 2'b00;
          if (req != 2'b00) begin
            dono     <= vencedor;
            restante <= dur_vencedor;
            gnt      <= um_quente(vencedor);
            ocupado  <= 1'b1;
            if (dur_vencedor != '0) begin
              estado <= CONTA;
            end else begin
              estado <= FIM;
              done   <= um_quente(vencedor);
            end
          end
        end
        CONTA: begin
          // Abort wins over a coincident final tick: no done without a held request.
          if (!req[dono]) begin
            estado   <= IDLE;
            gnt      <= 2'b00;
            ocupado  <= 1'b0;
            restante <= '0;
            rr       <= ~dono;
          end else if (fim) begin
            if (restante > W'(1)) begin
              restante <= restante - 1'b1;
            end else begin
              restante <= '0;
              estado   <= FIM;
              done     <= um_quente(dono);
            end
          end
        end
        FIM: begin
          estado  <= IDLE;
          gnt     <= 2'b00;
          done    <= 2'b00;
          ocupado <= 1'b0;
          rr      <= ~dono;
        end
        default: begin
          estado   <= IDLE;
          gnt      <= 2'b00;
          done     <= 2'b00;
          ocupado  <= 1'b0;
          restante <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_temporizador.sv
// tb/tb_arbitro_temporizador.sv - scoreboard bench for arbitro_temporizador against an interval-level model
module tb_arbitro_temporizador;

  localparam int M = 4;
  localparam int W = 8;

  logic         clock = 1'b0;
  logic         zera_as_n = 1'b0;
  logic [1:0]   req = 2'b00;
  logic [W-1:0] dur0 = '0;
  logic [W-1:0] dur1 = '0;
  logic [1:0]   gnt;
  logic [1:0]   done;
  logic         ocupado;
  logic [W-1:0] restante;

  arbitro_temporizador #(.M(M), .W(W)) dut (
    .clock    (clock),
    .zera_as_n(zera_as_n),
    .req      (req),
    .dur0     (dur0),
    .dur1     (dur1),
    .gnt      (gnt),
    .done     (done),
    .ocupado  (ocupado),
    .restante (restante)
  );

  always #5 clock = ~clock;

  typedef struct {
    int dono;
    int ciclo;
  } evento_t;

  evento_t fila[$];
  int testes = 0;
  int falhas = 0;
  int cyc = 0;

  // Interval model: an owner, a start edge and a duration; done is due at t0 + d*M.
  bit m_tem = 0;
  bit m_fim = 0;
  bit m_rr = 0;
  int m_dono = 0;
  int m_t0 = 0;
  int m_d = 0;

  task automatic verifica(input string nome, input int atual, input int esperado);
    testes++;
    if (atual != esperado) begin
      falhas++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nome, atual, esperado, cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge clock or negedge zera_as_n);
      if (clock) cyc++;
      if (!zera_as_n) begin
        m_tem = 0;
        m_fim = 0;
        m_rr  = 0;
      end else if (clock) begin
        if (m_fim) begin
          m_tem = 0;
          m_fim = 0;
          m_rr  = (m_dono == 0);
        end else if (m_tem) begin
          if (!req[m_dono]) begin
            m_tem = 0;
            m_rr  = (m_dono == 0);
          end else if (cyc == m_t0 + m_d * M) begin
            m_fim = 1;
            fila.push_back('{m_dono, cyc});
          end
        end else if (req != 2'b00) begin
          m_dono = (req == 2'b11) ? int'(m_rr) : (req[1] ? 1 : 0);
          m_d    = (m_dono == 1) ? int'(dur1) : int'(dur0);
          m_t0   = cyc;
          m_tem  = 1;
          if (m_d == 0) begin
            m_fim = 1;
            fila.push_back('{m_dono, cyc});
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #3;
      verifica("gnt", int'(gnt), m_tem ? (1 << m_dono) : 0);
      verifica("ocupado", int'(ocupado), int'(m_tem));
      verifica("restante", int'(restante),
               (!m_tem || m_fim) ? 0 : m_d - (cyc - m_t0) / M);
      if (fila.size() > 0 && fila[0].ciclo < cyc) begin
        verifica("done_missing_cycle", cyc, fila[0].ciclo);
        void'(fila.pop_front());
      end
      if (done != 2'b00) begin
        if (fila.size() == 0) begin
          verifica("done_spurious", int'(done), 0);
        end else begin
          evento_t e;
          e = fila.pop_front();
          verifica("done_owner", int'(done), 1 << e.dono);
          verifica("done_cycle", cyc, e.ciclo);
        end
      end
    end
  end

  task automatic ciclos(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulso_reset(input int n);
    zera_as_n = 1'b0;
    #1;
    verifica("rst_gnt", int'(gnt), 0);
    verifica("rst_done", int'(done), 0);
    verifica("rst_ocupado", int'(ocupado), 0);
    verifica("rst_restante", int'(restante), 0);
    req = 2'b00;
    ciclos(n);
    zera_as_n = 1'b1;
  endtask

  initial begin
    ciclos(2);
    verifica("reset_gnt", int'(gnt), 0);
    verifica("reset_restante", int'(restante), 0);
    zera_as_n = 1'b1;
    ciclos(2);

    req = 2'b01; dur0 = 8'd3;
    ciclos(20);
    req = 2'b00; ciclos(3);

    pulso_reset(2);
    req = 2'b11; dur0 = 8'd1; dur1 = 8'd1;
    ciclos(20);
    req = 2'b00; ciclos(3);

    req = 2'b10; dur1 = 8'd0;
    ciclos(1);
    req = 2'b00; ciclos(3);

    req = 2'b01; dur0 = 8'd5;
    ciclos(7);
    req = 2'b00; ciclos(2);
    req = 2'b11; dur1 = 8'd2;
    ciclos(12);
    req = 2'b00; ciclos(3);

    req = 2'b01; dur0 = 8'd3;
    ciclos(6);
    pulso_reset(2);
    ciclos(20);

    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 7) == 0) req = 2'($urandom_range(0, 3));
      dur0 = W'($urandom_range(0, 3));
      dur1 = W'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) pulso_reset($urandom_range(1, 3));
      ciclos(1);
    end

    req = 2'b00;
    ciclos(40);
    verifica("scoreboard_empty", fila.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end

endmodule
